// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: issues one request at a time to instruction memory, parks a
// returned instruction in a skid register while decode stalls, and drains in-flight fetches after a redirect.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000060
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DRAIN
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] skid_pc, skid_pc_n;
    logic [31:0] skid_instr, skid_instr_n;
    logic [31:0] target, target_n;
    logic [31:0] pc_o_n, pc_plus4_o_n, instr_o_n;
    logic        valid_o_n;
    logic [31:0] pc_plus4, skid_pc_plus4;

    assign pc_plus4      = pc + 32'd4;
    assign skid_pc_plus4 = skid_pc + 32'd4;

    // HOLD already owns the instruction at pc, so no request is outstanding there.
    assign imem_read    = !rst && (state != HOLD);
    assign imem_address = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            skid_pc    <= '0;
            skid_instr <= '0;
            target     <= '0;
            pc_o       <= '0;
            pc_plus4_o <= '0;
            instr_o    <= '0;
            valid_o    <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            skid_pc    <= skid_pc_n;
            skid_instr <= skid_instr_n;
            target     <= target_n;
            pc_o       <= pc_o_n;
            pc_plus4_o <= pc_plus4_o_n;
            instr_o    <= instr_o_n;
            valid_o    <= valid_o_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        skid_pc_n    = skid_pc;
        skid_instr_n = skid_instr;
        target_n     = target;
        pc_o_n       = pc_o;
        pc_plus4_o_n = pc_plus4_o;
        instr_o_n    = instr_o;
        valid_o_n    = valid_o;

        unique case (state)
            FETCH: begin
                if (redirect) begin
                    pc_o_n       = '0;
                    pc_plus4_o_n = '0;
                    instr_o_n    = '0;
                    valid_o_n    = 1'b0;
                    if (imem_resp) begin
                        pc_n = redirect_pc;
                    end else begin
                        // The request in flight must complete before pc may move.
                        target_n = redirect_pc;
                        state_n  = DRAIN;
                    end
                end else if (imem_resp) begin
                    if (stall) begin
                        skid_pc_n    = pc;
                        skid_instr_n = imem_rdata;
                        state_n      = HOLD;
                    end else begin
                        pc_o_n       = pc;
                        pc_plus4_o_n = pc_plus4;
                        instr_o_n    = imem_rdata;
                        valid_o_n    = 1'b1;
                        pc_n         = pc_plus4;
                    end
                end else if (!stall) begin
                    pc_o_n       = '0;
                    pc_plus4_o_n = '0;
                    instr_o_n    = '0;
                    valid_o_n    = 1'b0;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_o_n       = '0;
                    pc_plus4_o_n = '0;
                    instr_o_n    = '0;
                    valid_o_n    = 1'b0;
                    pc_n         = redirect_pc;
                    state_n      = FETCH;
                end else if (!stall) begin
                    pc_o_n       = skid_pc;
                    pc_plus4_o_n = skid_pc_plus4;
                    instr_o_n    = skid_instr;
                    valid_o_n    = 1'b1;
                    pc_n         = pc_plus4;
                    state_n      = FETCH;
                end
            end
            DRAIN: begin
                if (redirect || !stall) begin
                    pc_o_n       = '0;
                    pc_plus4_o_n = '0;
                    instr_o_n    = '0;
                    valid_o_n    = 1'b0;
                end
                if (imem_resp) begin
                    pc_n    = redirect ? redirect_pc : target;
                    state_n = FETCH;
                end else if (redirect) begin
                    target_n = redirect_pc;
                end
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized scoreboard bench for if_fetch_unit: a behavioural fetch-stream model predicts the
// delivered instructions and request addresses; a monitor checks decode-side outputs every cycle.
module tb_if_fetch_unit;

    localparam logic [31:0] MAIN_RESET_PC = 32'h00000060;
    localparam int NUM_CYCLES = 3000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } entry_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic [31:0] instr_o;
    logic        valid_o;

    logic        w_read;
    logic [31:0] w_addr;
    logic [31:0] w_pc_o;
    logic [31:0] w_pc4;
    logic [31:0] w_instr;
    logic        w_valid;
    logic        w_zero;
    logic [31:0] w_zero32;
    logic [31:0] w_nop;

    int checks = 0;
    int errors = 0;

    entry_t sb[$];

    // Fetch-stream model state: next address to fetch, a parked instruction, a pending redirect.
    logic [31:0] m_pc;
    logic        m_parked;
    logic [31:0] m_park_pc;
    logic        m_discard;
    logic [31:0] m_target;

    logic        busy;
    int          wait_left;

    if_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .pc_o         (pc_o),
        .pc_plus4_o   (pc_plus4_o),
        .instr_o      (instr_o),
        .valid_o      (valid_o)
    );

    // Second instance exercises the 32-bit wrap of the program counter with zero-wait memory.
    assign w_zero   = 1'b0;
    assign w_zero32 = 32'd0;
    assign w_nop    = 32'h00000013;

    if_fetch_unit #(.RESET_PC(32'hFFFFFFFC)) u_wrap (
        .clk          (clk),
        .rst          (rst),
        .stall        (w_zero),
        .redirect     (w_zero),
        .redirect_pc  (w_zero32),
        .imem_read    (w_read),
        .imem_address (w_addr),
        .imem_rdata   (w_nop),
        .imem_resp    (w_read),
        .pc_o         (w_pc_o),
        .pc_plus4_o   (w_pc4),
        .instr_o      (w_instr),
        .valid_o      (w_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E3779B1) ^ 32'h00000013;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushDelivery(input logic [31:0] pc);
        entry_t e;
        e.pc    = pc;
        e.pc4   = pc + 32'd4;
        e.instr = mem_word(pc);
        sb.push_back(e);
    endtask

    // Each edge: decide what the fetch stream does with this cycle's inputs.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_pc      = MAIN_RESET_PC;
                m_parked  = 1'b0;
                m_park_pc = '0;
                m_discard = 1'b0;
                m_target  = '0;
                sb.delete();
            end else if (m_parked) begin
                if (redirect) begin
                    m_parked = 1'b0;
                    m_pc     = redirect_pc;
                end else if (!stall) begin
                    pushDelivery(m_park_pc);
                    m_parked = 1'b0;
                    m_pc     = m_pc + 32'd4;
                end
            end else if (m_discard) begin
                if (imem_resp) begin
                    m_pc      = redirect ? redirect_pc : m_target;
                    m_discard = 1'b0;
                end else if (redirect) begin
                    m_target = redirect_pc;
                end
            end else if (imem_resp) begin
                if (redirect) begin
                    m_pc = redirect_pc;
                end else if (stall) begin
                    m_parked  = 1'b1;
                    m_park_pc = m_pc;
                end else begin
                    pushDelivery(m_pc);
                    m_pc = m_pc + 32'd4;
                end
            end else if (redirect) begin
                m_discard = 1'b1;
                m_target  = redirect_pc;
            end
        end
    end

    // Monitor: tracks what decode should currently see, popping a new entry whenever the DUT presents one.
    initial begin
        logic   s, r, ra;
        entry_t cur;
        logic   cur_valid;
        cur       = '0;
        cur_valid = 1'b0;
        forever begin
            @(posedge clk);
            ra = rst;
            s  = stall;
            r  = redirect;
            #1;
            if (ra || rst) begin
                cur       = '0;
                cur_valid = 1'b0;
            end else begin
                if (r) begin
                    cur       = '0;
                    cur_valid = 1'b0;
                end else if (!s) begin
                    if (valid_o && sb.size() > 0) begin
                        cur       = sb.pop_front();
                        cur_valid = 1'b1;
                    end else begin
                        cur       = '0;
                        cur_valid = 1'b0;
                    end
                end
                checkOutput(r ? "out_redirect" : (s ? "out_stalled" : "out_update"),
                            {valid_o, pc_o, pc_plus4_o, instr_o},
                            {cur_valid, cur.pc, cur.pc4, cur.instr});
            end
        end
    end

    // Called just after a negedge: check the request, then drive the next cycle's inputs.
    task automatic applyStimulus(input bit directed);
        if (m_parked) begin
            checkOutput("imem_read_hold", imem_read, 1'b0);
        end else begin
            checkOutput("imem_read", imem_read, 1'b1);
            checkOutput("imem_address", imem_address, m_pc);
        end

        if (directed) begin
            stall    = 1'b0;
            redirect = 1'b0;
        end else begin
            stall    = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 5) == 0);
        end
        redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 : ($urandom & 32'h0000FFFC);

        if (!imem_read) begin
            busy      = 1'b0;
            imem_resp = 1'b0;
        end else begin
            if (!busy) begin
                busy      = 1'b1;
                wait_left = directed ? 0 : $urandom_range(0, 3);
            end
            if (wait_left == 0) begin
                imem_resp  = 1'b1;
                imem_rdata = mem_word(imem_address);
                busy       = 1'b0;
            end else begin
                imem_resp  = 1'b0;
                imem_rdata = $urandom;
                wait_left--;
            end
        end
    endtask

    task automatic checkReset();
        checkOutput("rst_imem_read", imem_read, 1'b0);
        checkOutput("rst_imem_address", imem_address, MAIN_RESET_PC);
        checkOutput("rst_outputs", {valid_o, pc_o, pc_plus4_o, instr_o}, 97'd0);
        checkOutput("rst_wrap_address", w_addr, 32'hFFFFFFFC);
    endtask

    initial begin
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_resp   = 1'b0;
        imem_rdata  = '0;
        busy        = 1'b0;
        wait_left   = 0;
        #3;
        checkReset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        applyStimulus(1'b1);

        for (int c = 0; c < NUM_CYCLES; c++) begin
            @(negedge clk);
            if (c == 0) begin
                checkOutput("wrap_first", {w_valid, w_pc_o, w_pc4}, {1'b1, 32'hFFFFFFFC, 32'h00000000});
                checkOutput("wrap_second_addr", w_addr, 32'h00000000);
            end
            if (c == 1) begin
                checkOutput("wrap_second", {w_valid, w_pc_o, w_pc4}, {1'b1, 32'h00000000, 32'h00000004});
            end
            if (c == NUM_CYCLES / 2) begin
                rst       = 1'b1;
                stall     = 1'b0;
                redirect  = 1'b0;
                imem_resp = 1'b0;
                busy      = 1'b0;
                #1;
                checkReset();
                repeat (2) @(negedge clk);
                rst = 1'b0;
                #1;
            end
            applyStimulus(c < 6 || (c > NUM_CYCLES / 2 && c < NUM_CYCLES / 2 + 6));
        end

        @(negedge clk);
        stall    = 1'b0;
        redirect = 1'b0;
        @(negedge clk);
        checkOutput("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000060, meaning PC loaded on reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port stall  input  1  hold IF/ID output registers (hazard unit).
REQ-005 SHALL have port redirect  input  1  taken branch/jump from EX; flushes fetch.
REQ-006 SHALL have port redirect_pc  input  32  redirect target.
REQ-007 SHALL have port imem_read  output  1  instruction memory request.
REQ-008 SHALL have port imem_address  output  32  request address.
REQ-009 SHALL have port imem_rdata  input  32  returned instruction, valid when imem_resp=1.
REQ-010 SHALL have port imem_resp  input  1  single-cycle response strobe.
REQ-011 SHALL have ports pc_o (32), pc_plus4_o (32), instr_o (32), valid_o (1), all outputs, registered IF/ID payload to decode.

Function
REQ-012 SHALL implement FSM with states FETCH, HOLD, DRAIN.
REQ-013 SHALL drive imem_read=1 in FETCH and DRAIN, 0 in HOLD.
REQ-014 SHALL drive imem_address = internal pc register; pc SHALL NOT change while imem_read=1 and imem_resp=0 (request stable until response).
REQ-015 FETCH, imem_resp=1, redirect=0, stall=0: outputs <= {pc, pc+4, imem_rdata, valid=1}; pc <= pc+4; stay FETCH (throughput 1 instr/cycle with zero-wait memory).
REQ-016 FETCH, imem_resp=1, redirect=0, stall=1: capture {pc, imem_rdata} in skid register; outputs hold; go HOLD.
REQ-017 HOLD, stall=0, redirect=0: outputs <= skid payload with valid=1; pc <= pc+4; go FETCH.
REQ-018 HOLD, stall=1, redirect=0: all state and outputs hold.
REQ-019 FETCH, imem_resp=0, redirect=0: if stall=0, valid_o <= 0 and instr_o/pc_o/pc_plus4_o <= 0 (bubble); if stall=1, outputs hold.
REQ-020 redirect=1 SHALL take priority over stall: outputs <= all zero, valid_o <= 0 at the next edge.
REQ-021 redirect in FETCH with imem_resp=1, or in HOLD: discard fetched/skid data; pc <= redirect_pc; go FETCH.
REQ-022 redirect in FETCH with imem_resp=0: latch redirect_pc in target register; go DRAIN; pc unchanged.
REQ-023 DRAIN: on imem_resp=1, discard imem_rdata, pc <= target (or redirect_pc if redirect=1 same cycle), go FETCH; without resp, a new redirect overwrites target (latest wins); outputs stay bubble (valid_o=0) unless stall=1, in which case they hold.
REQ-024 pc arithmetic SHALL be 32-bit modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000); pc_plus4_o computed the same way.
REQ-025 valid_o=1 SHALL appear only for an instruction whose response arrived with no redirect pending or concurrent.

Reset
REQ-026 While rst=1: pc = RESET_PC, state = FETCH, imem_read = 0, pc_o/pc_plus4_o/instr_o/skid/target = 0, valid_o = 0, independent of clk.
REQ-027 First posedge after rst deasserts SHALL see imem_read=1, imem_address=RESET_PC.
REQ-028 Reset mid-request (FETCH/DRAIN/HOLD) SHALL abandon the request; any late imem_resp after reset release for the abandoned request is outside contract.

Verification
REQ-029 Reset, memory responds every cycle with rdata=0x00000013 -> valid_o=1 on cycle 2 onward, pc_o sequence 0x60, 0x64, 0x68, pc_plus4_o = pc_o+4.
REQ-030 Response at pc 0x64 coincides with stall=1 for 3 cycles -> imem_read=0 during HOLD, outputs frozen on 0x60, then pc_o=0x64 with skid instr one cycle after stall drops.
REQ-031 Memory with 3-cycle latency, redirect to 0x200 on cycle 1 of wait -> imem_address stays 0x68 until resp, resp data discarded (valid_o=0), next imem_address=0x200.
REQ-032 redirect=1 with stall=1 -> next edge valid_o=0, instr_o=0 despite stall.
REQ-033 Two redirects (0x300 then 0x400) during one DRAIN -> next request address 0x400.
REQ-034 RESET_PC=0xFFFFFFFC, zero-wait memory -> second fetch address 0x00000000, pc_plus4_o of first instr = 0x00000000.
